// File: rtl/simple_bus_responder.sv
// simple_bus_responder: 8-bit request/response slave with RAM and CSRs.
// Fixed wait-state latency, one registered response per accepted request.
module simple_bus_responder #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_req,
    input  logic       s_rw,
    input  logic [7:0] s_addr,
    input  logic [7:0] s_wdata,
    output logic [7:0] s_rdata,
    output logic       s_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_HOLD
    } state_t;

    localparam bit LP_NOWAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] LP_LOAD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_rw;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic       r_valid;
    logic [7:0] r_wcnt;
    logic [1:0] r_status;
    logic [7:0] r_mem [0:63];

    logic       w_accept;
    logic       w_commit;
    logic       w_rw;
    logic [7:0] w_addr;
    logic [7:0] w_wdata;
    logic       w_ram;
    logic       w_id;
    logic       w_wc;
    logic       w_st;
    logic       w_unm;
    logic [7:0] w_rd_data;

    // With no wait states the access commits on the accepting edge,
    // before the capture registers are loaded, so bypass them in IDLE.
    assign w_accept = (r_state == ST_IDLE) && s_req;
    assign w_commit = (w_accept && LP_NOWAIT)
                    || ((r_state == ST_WAIT) && (r_cnt == 4'd0));
    assign w_rw    = (r_state == ST_IDLE) ? s_rw    : r_rw;
    assign w_addr  = (r_state == ST_IDLE) ? s_addr  : r_addr;
    assign w_wdata = (r_state == ST_IDLE) ? s_wdata : r_wdata;

    assign w_ram = (w_addr[7:6] == 2'b00);
    assign w_id  = (w_addr == 8'h40);
    assign w_wc  = (w_addr == 8'h41);
    assign w_st  = (w_addr == 8'h42);
    assign w_unm = !(w_ram || w_id || w_wc || w_st);

    // Read mux over the address map; unmapped reads return zero
    always_comb begin
        w_rd_data = 8'h00;
        unique case (1'b1)
            w_ram:   w_rd_data = r_mem[w_addr[5:0]];
            w_id:    w_rd_data = 8'hA5;
            w_wc:    w_rd_data = r_wcnt;
            w_st:    w_rd_data = {6'b0, r_status};
            default: w_rd_data = 8'h00;
        endcase
    end

    // Handshake FSM with capture, wait counter and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_rw    <= 1'b0;
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (s_req) begin
                        r_rw    <= s_rw;
                        r_addr  <= s_addr;
                        r_wdata <= s_wdata;
                        if (LP_NOWAIT) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= LP_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= s_req ? ST_HOLD : ST_IDLE;
                end
                ST_HOLD: begin
                    if (!s_req) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_commit) begin
                r_valid <= 1'b1;
                r_rdata <= w_rw ? w_rd_data : 8'h00;
            end
        end
    end

    // Write counter and sticky error flags, updated on the commit edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt   <= 8'h00;
            r_status <= 2'b00;
        end else if (w_commit) begin
            if (!w_rw) begin
                unique case (1'b1)
                    w_ram:   r_wcnt      <= r_wcnt + 8'd1;
                    w_id:    r_status[1] <= 1'b1;
                    w_wc:    r_wcnt      <= 8'h00;
                    w_st:    r_status    <= r_status & ~w_wdata[1:0];
                    default: r_status[0] <= 1'b1;
                endcase
            end else if (w_unm) begin
                r_status[0] <= 1'b1;
            end
        end
    end

    // RAM array is deliberately not reset
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && !w_rw && w_ram) begin
            r_mem[w_addr[5:0]] <= w_wdata;
        end
    end

    assign s_rdata = r_rdata;
    assign s_valid = r_valid;

endmodule

// File: tb/tb_simple_bus_responder.sv
// tb_simple_bus_responder: directed checks on two instances,
// WAIT_CYCLES=2 (inst a) and WAIT_CYCLES=0 (inst b).
module tb_simple_bus_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0, a_rw = 1'b0;
    logic [7:0] a_addr = 8'h00, a_wdata = 8'h00;
    logic [7:0] a_rdata;
    logic       a_valid;
    logic       b_req = 1'b0, b_rw = 1'b0;
    logic [7:0] b_addr = 8'h00, b_wdata = 8'h00;
    logic [7:0] b_rdata;
    logic       b_valid;

    int n_chk = 0;
    int n_pass = 0;

    simple_bus_responder #(.WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst_n(rst_n),
        .s_req(a_req), .s_rw(a_rw),
        .s_addr(a_addr), .s_wdata(a_wdata),
        .s_rdata(a_rdata), .s_valid(a_valid)
    );

    simple_bus_responder #(.WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .s_req(b_req), .s_rw(b_rw),
        .s_addr(b_addr), .s_wdata(b_wdata),
        .s_rdata(b_rdata), .s_valid(b_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic acc(input bit sel, input logic rw,
                       input logic [7:0] addr, input logic [7:0] wd,
                       output logic [7:0] rd, output int lat);
        @(negedge clk);
        if (sel) begin
            b_req = 1'b1; b_rw = rw; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_rw = rw; a_addr = addr; a_wdata = wd;
        end
        @(posedge clk);
        #1;
        a_req = 1'b0;
        b_req = 1'b0;
        lat = 99;
        rd = 8'h00;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if ((sel ? b_valid : a_valid) === 1'b1) begin
                lat = n;
                rd = sel ? b_rdata : a_rdata;
                break;
            end
        end
    endtask

    task automatic rd(input bit sel, input logic [7:0] addr,
                      input logic [7:0] exp, input string tag);
        logic [7:0] d;
        int l;
        acc(sel, 1'b1, addr, 8'h00, d, l);
        chk({tag, "_lat"}, 16'(l), sel ? 16'd1 : 16'd3);
        chk(tag, {8'h00, d}, {8'h00, exp});
    endtask

    task automatic wr(input bit sel, input logic [7:0] addr,
                      input logic [7:0] data, input string tag);
        logic [7:0] d;
        int l;
        acc(sel, 1'b0, addr, data, d, l);
        chk({tag, "_lat"}, 16'(l), sel ? 16'd1 : 16'd3);
        chk(tag, {8'h00, d}, 16'h0000);
    endtask

    initial begin
        logic [7:0] d;
        int l;
        int cnt;

        repeat (3) @(negedge clk);
        chk("rst_a_valid", {15'b0, a_valid}, 16'h0000);
        chk("rst_a_rdata", {8'h00, a_rdata}, 16'h0000);
        chk("rst_b_valid", {15'b0, b_valid}, 16'h0000);
        chk("rst_b_rdata", {8'h00, b_rdata}, 16'h0000);
        rst_n = 1'b1;

        wr(0, 8'h10, 8'h3C, "wr_10");
        rd(0, 8'h10, 8'h3C, "rd_10");
        rd(0, 8'h41, 8'h01, "wcnt_1");

        rd(0, 8'h40, 8'hA5, "rd_id");
        @(negedge clk);
        chk("rdata_held", {8'h00, a_rdata}, 16'h00A5);
        chk("valid_one", {15'b0, a_valid}, 16'h0000);
        wr(0, 8'h40, 8'h00, "wr_id");
        rd(0, 8'h42, 8'h02, "roerr");
        wr(0, 8'h42, 8'h02, "w1c_ro");
        rd(0, 8'h42, 8'h00, "st_clr");

        rd(0, 8'h80, 8'h00, "rd_unm");
        rd(0, 8'h42, 8'h01, "decerr");
        wr(0, 8'h42, 8'h01, "w1c_de");
        rd(0, 8'h42, 8'h00, "st_clr2");
        wr(0, 8'h41, 8'hFF, "wcnt_clr");
        rd(0, 8'h41, 8'h00, "wcnt_0");
        wr(0, 8'h90, 8'h12, "wr_unm");
        rd(0, 8'h42, 8'h01, "decerr_w");
        rd(0, 8'h41, 8'h00, "wcnt_unm");

        @(negedge clk);
        a_req = 1'b1; a_rw = 1'b1; a_addr = 8'h40;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (a_valid === 1'b1) cnt++;
        end
        chk("hold_one", 16'(cnt), 16'd1);
        chk("hold_data", {8'h00, a_rdata}, 16'h00A5);
        a_req = 1'b0;
        @(negedge clk);
        a_req = 1'b1; a_addr = 8'h10;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_valid === 1'b1) cnt++;
        end
        chk("rearm_one", 16'(cnt), 16'd1);
        chk("rearm_data", {8'h00, a_rdata}, 16'h003C);
        a_req = 1'b0;
        repeat (2) @(negedge clk);

        rd(1, 8'h41, 8'h00, "b_wcnt");
        wr(1, 8'h20, 8'h77, "b_wr");
        rd(1, 8'h20, 8'h77, "b_rd");
        rd(1, 8'h41, 8'h01, "b_wcnt1");

        wr(0, 8'h05, 8'h11, "wr_05");
        @(negedge clk);
        a_req = 1'b1; a_rw = 1'b0; a_addr = 8'h05; a_wdata = 8'h99;
        @(posedge clk);
        #1;
        a_req = 1'b0;
        cnt = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        if (a_valid === 1'b1) cnt++;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (a_valid === 1'b1) cnt++;
        end
        chk("abort_valid", 16'(cnt), 16'd0);
        chk("abort_rdata", {8'h00, a_rdata}, 16'h0000);
        rd(0, 8'h41, 8'h00, "abort_wcnt");
        rd(0, 8'h05, 8'h11, "abort_ram");

        for (int i = 0; i < 256; i++) begin
            acc(0, 1'b0, 8'(i % 64), 8'(i), d, l);
        end
        rd(0, 8'h41, 8'h00, "wcnt_wrap");
        rd(0, 8'h3F, 8'hFF, "ram_3f");
        rd(0, 8'h00, 8'hC0, "ram_00");
        rd(0, 8'h10, 8'hD0, "ram_10");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
